// File: rtl/memtest_databus_walker.sv
// Data-bus walking-bit tester: writes a walking one/zero to a fixed address,
// reads it back and compares per bit, capturing the first failure.
module memtest_databus_walker #(
    parameter int unsigned DATUM_WIDTH    = 8,
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    input  logic                           i_mode,
    input  logic [ADDR_WIDTH-1:0]          i_test_address,
    output logic [ADDR_WIDTH-1:0]          o_mem_addr,
    output logic                           o_mem_wr_valid,
    output logic [DATUM_WIDTH-1:0]         o_mem_wr_data,
    input  logic                           i_mem_wr_ready,
    output logic                           o_mem_rd_req,
    input  logic                           i_mem_rd_valid,
    input  logic [DATUM_WIDTH-1:0]         i_mem_rd_data,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_error,
    output logic                           o_timeout,
    output logic [DATUM_WIDTH-1:0]         o_fail_pattern,
    output logic [DATUM_WIDTH-1:0]         o_fail_data,
    output logic [$clog2(DATUM_WIDTH)-1:0] o_fail_index
);

    localparam int unsigned DW = DATUM_WIDTH;
    localparam int unsigned AW = ADDR_WIDTH;
    localparam int unsigned IW = $clog2(DATUM_WIDTH);
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_RD_REQ,
        S_RD_WAIT,
        S_COMPARE,
        S_ERROR,
        S_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   pattern_q, pattern_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            wr_valid_q, wr_valid_d;
    logic            rd_req_q, rd_req_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic            timeout_q, timeout_d;
    logic [DW-1:0]   fail_pattern_q, fail_pattern_d;
    logic [DW-1:0]   fail_data_q, fail_data_d;
    logic [IW-1:0]   fail_index_q, fail_index_d;
    logic            fail_now, fail_tmo;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        pattern_d      = pattern_q;
        idx_d          = idx_q;
        tmo_d          = tmo_q;
        rdata_d        = rdata_q;
        error_d        = error_q;
        timeout_d      = timeout_q;
        fail_pattern_d = fail_pattern_q;
        fail_data_d    = fail_data_q;
        fail_index_d   = fail_index_q;
        fail_now       = 1'b0;
        fail_tmo       = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    addr_d         = i_test_address;
                    error_d        = 1'b0;
                    timeout_d      = 1'b0;
                    fail_pattern_d = '0;
                    fail_data_d    = '0;
                    fail_index_d   = '0;
                    idx_d          = '0;
                    tmo_d          = '0;
                    pattern_d      = i_mode ? ~DW'(1) : DW'(1);
                    state_d        = S_WRITE;
                end
            end
            S_WRITE: begin
                if (i_mem_wr_ready) begin
                    state_d = S_RD_REQ;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fail_now = 1'b1;
                    fail_tmo = 1'b1;
                    state_d  = S_ERROR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_RD_REQ: begin
                tmo_d   = '0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (i_mem_rd_valid) begin
                    rdata_d = i_mem_rd_data;
                    state_d = S_COMPARE;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    fail_now = 1'b1;
                    fail_tmo = 1'b1;
                    state_d  = S_ERROR;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            S_COMPARE: begin
                if (rdata_q != pattern_q) begin
                    fail_now = 1'b1;
                    state_d  = S_ERROR;
                end else if (idx_q == IW'(DW - 1)) begin
                    state_d = S_DONE;
                end else begin
                    // Rotation keeps a single 1 (or single 0) moving left
                    pattern_d = {pattern_q[DW-2:0], pattern_q[DW-1]};
                    idx_d     = idx_q + IW'(1);
                    tmo_d     = '0;
                    state_d   = S_WRITE;
                end
            end
            S_ERROR: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Failure info is captured on entry so it is visible during ERROR
        if (fail_now) begin
            error_d        = 1'b1;
            timeout_d      = fail_tmo;
            fail_pattern_d = pattern_q;
            fail_data_d    = fail_tmo ? '0 : rdata_q;
            fail_index_d   = idx_q;
        end

        wr_valid_d = (state_d == S_WRITE);
        rd_req_d   = (state_d == S_RD_REQ);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            pattern_q      <= '0;
            idx_q          <= '0;
            tmo_q          <= '0;
            rdata_q        <= '0;
            wr_valid_q     <= 1'b0;
            rd_req_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            timeout_q      <= 1'b0;
            fail_pattern_q <= '0;
            fail_data_q    <= '0;
            fail_index_q   <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            pattern_q      <= pattern_d;
            idx_q          <= idx_d;
            tmo_q          <= tmo_d;
            rdata_q        <= rdata_d;
            wr_valid_q     <= wr_valid_d;
            rd_req_q       <= rd_req_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            error_q        <= error_d;
            timeout_q      <= timeout_d;
            fail_pattern_q <= fail_pattern_d;
            fail_data_q    <= fail_data_d;
            fail_index_q   <= fail_index_d;
        end
    end

    assign o_mem_addr     = addr_q;
    assign o_mem_wr_valid = wr_valid_q;
    assign o_mem_wr_data  = pattern_q;
    assign o_mem_rd_req   = rd_req_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_error        = error_q;
    assign o_timeout      = timeout_q;
    assign o_fail_pattern = fail_pattern_q;
    assign o_fail_data    = fail_data_q;
    assign o_fail_index   = fail_index_q;

endmodule

// File: tb/tb_memtest_databus_walker.sv
// Randomized bench for memtest_databus_walker against a stalling, faultable
// memory model and an arithmetic expectation of patterns, timing and failure.
module tb_memtest_databus_walker;

    localparam int W  = 8;
    localparam int AW = 16;
    localparam int T  = 6;

    logic          clk;
    logic          i_rst;
    logic          i_start;
    logic          i_mode;
    logic [AW-1:0] i_test_address;
    logic [AW-1:0] o_mem_addr;
    logic          o_mem_wr_valid;
    logic [W-1:0]  o_mem_wr_data;
    logic          i_mem_wr_ready;
    logic          o_mem_rd_req;
    logic          i_mem_rd_valid;
    logic [W-1:0]  i_mem_rd_data;
    logic          o_busy;
    logic          o_done;
    logic          o_error;
    logic          o_timeout;
    logic [W-1:0]  o_fail_pattern;
    logic [W-1:0]  o_fail_data;
    logic [2:0]    o_fail_index;

    int checks = 0;
    int errors = 0;

    int           ws [W];
    int           rs [W];
    logic [W-1:0] s0;
    logic [W-1:0] s1;

    memtest_databus_walker #(
        .DATUM_WIDTH   (W),
        .ADDR_WIDTH    (AW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_mode        (i_mode),
        .i_test_address(i_test_address),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wr_valid(o_mem_wr_valid),
        .o_mem_wr_data (o_mem_wr_data),
        .i_mem_wr_ready(i_mem_wr_ready),
        .o_mem_rd_req  (o_mem_rd_req),
        .i_mem_rd_valid(i_mem_rd_valid),
        .i_mem_rd_data (i_mem_rd_data),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_error       (o_error),
        .o_timeout     (o_timeout),
        .o_fail_pattern(o_fail_pattern),
        .o_fail_data   (o_fail_data),
        .o_fail_index  (o_fail_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] pat_of(input bit mode, input int k);
        logic [W-1:0] p;
        p = W'(1) << k;
        return mode ? ~p : p;
    endfunction

    task automatic set_plan(input int w, input int r);
        for (int k = 0; k < W; k++) begin
            ws[k] = w;
            rs[k] = r;
        end
    endtask

    task automatic run_test(input bit mode, input logic [AW-1:0] addr, input bit noisy);
        int t, fk, nwr, exp_done;
        bit fail, tmo;
        logic [W-1:0] fdata, fpat, mem;
        int cyc, kw, wcnt, kr, rcnt, nreq, done_at;
        bit reading;

        // Expected outcome from per-pattern stall budgets and stuck bits
        t = 1; fk = 0; nwr = 0; fail = 0; tmo = 0; fdata = '0;
        for (int k = 0; k < W && !fail; k++) begin
            logic [W-1:0] p, rb;
            p = pat_of(mode, k);
            if (ws[k] >= T) begin
                t += T; fail = 1; tmo = 1; fk = k;
            end else begin
                t += ws[k] + 2;
                nwr++;
                if (rs[k] >= T) begin
                    t += T; fail = 1; tmo = 1; fk = k;
                end else begin
                    t += rs[k] + 2;
                    rb = (p & ~s0) | s1;
                    if (rb != p) begin
                        fail = 1; fk = k; fdata = rb;
                    end
                end
            end
        end
        exp_done = fail ? t + 1 : t;
        fpat     = fail ? pat_of(mode, fk) : '0;

        i_mode = mode; i_test_address = addr; i_start = 1'b1;
        i_mem_wr_ready = 1'b0; i_mem_rd_valid = 1'b0; i_mem_rd_data = '0;
        @(posedge clk); #1;

        cyc = 1; kw = 0; wcnt = 0; kr = 0; rcnt = 0; nreq = 0; done_at = 0;
        reading = 0; mem = '0;
        while (cyc < 1000 && done_at == 0) begin
            if (cyc == 1) begin
                check("busy_start", o_busy, 1);
                check("err_cleared", o_error, 0);
                check("fpat_cleared", o_fail_pattern, 0);
            end
            if (o_mem_wr_valid) begin
                check("wr_data", o_mem_wr_data, pat_of(mode, kw));
                check("wr_addr", o_mem_addr, addr);
                if (wcnt >= ws[kw]) begin
                    i_mem_wr_ready = 1'b1;
                    mem = (o_mem_wr_data & ~s0) | s1;
                    kw++;
                    wcnt = 0;
                end else begin
                    i_mem_wr_ready = 1'b0;
                    wcnt++;
                end
            end else begin
                i_mem_wr_ready = 1'b0;
            end
            if (reading && rcnt >= rs[kr]) begin
                i_mem_rd_valid = 1'b1;
                i_mem_rd_data  = mem;
                reading = 0;
                kr++;
            end else begin
                if (reading) rcnt++;
                i_mem_rd_valid = 1'b0;
                i_mem_rd_data  = W'($urandom);
            end
            if (o_mem_rd_req) begin
                reading = 1;
                rcnt = 0;
                nreq++;
            end
            if (noisy) begin
                i_start = 1'($urandom);
                i_mode  = 1'($urandom);
                i_test_address = AW'($urandom);
            end else begin
                i_start = 1'b0;
            end
            if (o_done) begin
                done_at = cyc;
                i_start = 1'b0;
                check("busy_at_done", o_busy, 1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        i_mem_wr_ready = 1'b0;
        i_mem_rd_valid = 1'b0;

        if (done_at == 0) check("done_seen", 0, 1);
        check("done_cycle", done_at, exp_done);
        check("done_pulse", o_done, 0);
        check("busy_after", o_busy, 0);
        check("error", o_error, fail);
        check("timeout", o_timeout, tmo);
        check("fail_pattern", o_fail_pattern, fpat);
        check("fail_data", o_fail_data, fdata);
        check("fail_index", o_fail_index, fail ? fk : 0);
        check("writes", kw, nwr);
        check("rd_reqs", nreq, nwr);
        @(posedge clk); #1;
        check("error_hold", o_error, fail);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_wrv"}, o_mem_wr_valid, 0);
        check({tag, "_wrd"}, o_mem_wr_data, 0);
        check({tag, "_addr"}, o_mem_addr, 0);
        check({tag, "_rdreq"}, o_mem_rd_req, 0);
        check({tag, "_done"}, o_done, 0);
        check({tag, "_err"}, o_error, 0);
        check({tag, "_tmo"}, o_timeout, 0);
        check({tag, "_fpat"}, o_fail_pattern, 0);
        check({tag, "_fdat"}, o_fail_data, 0);
        check({tag, "_fidx"}, o_fail_index, 0);
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_mode = 1'b0; i_test_address = '0;
        i_mem_wr_ready = 1'b0; i_mem_rd_valid = 1'b0; i_mem_rd_data = '0;
        s0 = '0; s1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        i_rst = 1'b0;
        @(posedge clk); #1;

        // Ideal echo memory, both modes
        set_plan(0, 0);
        run_test(1'b0, 16'h0040, 1'b0);
        run_test(1'b1, 16'h0040, 1'b0);

        // Data bit 3 stuck at 0
        s0 = 8'h08;
        run_test(1'b0, 16'h0040, 1'b0);
        s0 = '0;

        // Write stalls and slow reads, with start noise while busy
        set_plan(3, 4);
        run_test(1'b0, 16'h1234, 1'b1);

        // Read valid never arrives
        set_plan(0, 0);
        rs[0] = 1000;
        run_test(1'b0, 16'h0040, 1'b0);

        // Reset mid-write with start held high
        set_plan(1000, 0);
        i_mode = 1'b1; i_test_address = 16'hBEEF; i_start = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_wrv", o_mem_wr_valid, 1);
        i_rst = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midrst");
        i_rst = 1'b0; i_start = 1'b0;
        @(posedge clk); #1;
        check("post_rst_busy", o_busy, 0);

        // Randomized plans and faults
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < W; k++) begin
                ws[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, T + 1)) : int'($urandom_range(0, 2));
                rs[k] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, T + 1)) : int'($urandom_range(0, 2));
            end
            s0 = '0; s1 = '0;
            case ($urandom_range(0, 3))
                2:       s0 = W'(1) << $urandom_range(0, W - 1);
                3:       s1 = W'(1) << $urandom_range(0, W - 1);
                default: ;
            endcase
            run_test(1'($urandom), AW'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
